// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
// Fetch FSM encoding, the bubble instruction and the PC step.
package mips_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between fetch and imem.
// The fetch side is the master; the memory answers as the slave.
interface fetch_unit_if #(
    parameter int AW = 32
);

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rdy;
    logic [31:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold, flush and load.
// A one-entry skid buffer catches a word that completes while D is held.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          load,
    input  logic [31:0]   instr_in,
    input  logic [AW-1:0] pc4_in,
    output logic [31:0]   instr_D,
    output logic [AW-1:0] pc_plus4_D,
    output logic          valid_D,
    output logic          buf_valid
);

    logic [31:0]   reg_instr_q, reg_instr_d;
    logic [AW-1:0] reg_pc4_q, reg_pc4_d;
    logic          reg_valid_q, reg_valid_d;
    logic [31:0]   buf_instr_q, buf_instr_d;
    logic [AW-1:0] buf_pc4_q, buf_pc4_d;
    logic          buf_valid_q, buf_valid_d;

    always_comb begin
        reg_instr_d = reg_instr_q;
        reg_pc4_d   = reg_pc4_q;
        reg_valid_d = reg_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        buf_valid_d = buf_valid_q;
        if (!stall) begin
            if (flush) begin
                reg_instr_d = NOP_INSTR;
                reg_pc4_d   = '0;
                reg_valid_d = 1'b0;
                buf_valid_d = 1'b0;
            end else if (buf_valid_q) begin
                reg_instr_d = buf_instr_q;
                reg_pc4_d   = buf_pc4_q;
                reg_valid_d = 1'b1;
                buf_valid_d = load;
                if (load) begin
                    buf_instr_d = instr_in;
                    buf_pc4_d   = pc4_in;
                end
            end else if (load) begin
                reg_instr_d = instr_in;
                reg_pc4_d   = pc4_in;
                reg_valid_d = 1'b1;
            end else begin
                reg_instr_d = NOP_INSTR;
                reg_pc4_d   = '0;
                reg_valid_d = 1'b0;
            end
        end else if (load) begin
            // D is frozen: park the word until the stall lifts
            buf_instr_d = instr_in;
            buf_pc4_d   = pc4_in;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_instr_q <= NOP_INSTR;
            reg_pc4_q   <= '0;
            reg_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc4_q   <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            reg_instr_q <= reg_instr_d;
            reg_pc4_q   <= reg_pc4_d;
            reg_valid_q <= reg_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign instr_D    = reg_instr_q;
    assign pc_plus4_D = reg_pc4_q;
    assign valid_D    = reg_valid_q;
    assign buf_valid  = buf_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the pipelined MIPS: PC, wait-state imem FSM, redirect
// handling and the IF/ID register.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          H_stall_F,
    input  logic          H_stall_D,
    input  logic          pc_src_D,
    input  logic [AW-1:0] pc_branch_D,
    input  logic          jump_D,
    input  logic [AW-1:0] pc_jump_D,
    fetch_unit_if.master  imem,
    output logic [31:0]   instr_D,
    output logic [AW-1:0] pc_plus4_D,
    output logic          valid_D,
    output logic          fetch_busy
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] target;
    logic          redirect;
    logic          req;
    logic          load;
    logic          buf_valid;

    assign redirect = (jump_D | pc_src_D) & ~H_stall_D;
    assign target   = jump_D ? pc_jump_D : pc_branch_D;
    assign pc_plus4 = pc_q + AW'(PC_INC);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        req     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                req = ~H_stall_F & ~buf_valid;
                if (redirect && (!req || imem.imem_rdy)) begin
                    pc_d = target;
                end else if (req && imem.imem_rdy) begin
                    pc_d = pc_plus4;
                    load = 1'b1;
                end else if (req) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                    if (redirect) tgt_d = target;
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (imem.imem_rdy) begin
                    state_d = S_RUN;
                    pc_d    = redirect ? target : pc_plus4;
                    load    = ~redirect;
                end else if (redirect) begin
                    tgt_d   = target;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // stale request must finish before the redirect takes effect
                req = 1'b1;
                if (imem.imem_rdy) begin
                    pc_d    = tgt_q;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC[AW-1:0];
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign fetch_busy     = req & ~imem.imem_rdy;

    if_id_reg #(
        .AW(AW)
    ) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (H_stall_D),
        .flush     (redirect),
        .load      (load),
        .instr_in  (imem.imem_rdata),
        .pc4_in    (pc_plus4),
        .instr_D   (instr_D),
        .pc_plus4_D(pc_plus4_D),
        .valid_D   (valid_D),
        .buf_valid (buf_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random run scored
// against a transaction-level model of the fetch path.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        sf, sd, ps, jp, rdy;
    logic [31:0] pb, pj;
    logic [31:0] instr_D, pc_plus4_D;
    logic        valid_D, fetch_busy;
    logic        word_en;
    logic [31:0] force_word;

    int n_pass;
    int n_total;

    // model state: PC, outstanding request, doomed flag, skid queue, D
    logic [31:0] m_pc, m_tgt;
    logic        m_pending, m_doomed, m_req;
    logic [63:0] m_buf[$];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;

    fetch_unit_if #(.AW(32)) bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    assign bus.imem_rdy   = rdy;
    assign bus.imem_rdata = word_en ? force_word : mem_word(bus.imem_addr);

    fetch_unit #(
        .RESET_PC(32'h0),
        .AW      (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .H_stall_F  (sf),
        .H_stall_D  (sd),
        .pc_src_D   (ps),
        .pc_branch_D(pb),
        .jump_D     (jp),
        .pc_jump_D  (pj),
        .imem       (bus),
        .instr_D    (instr_D),
        .pc_plus4_D (pc_plus4_D),
        .valid_D    (valid_D),
        .fetch_busy (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0;
        m_tgt = 32'h0;
        m_pending = 1'b0;
        m_doomed = 1'b0;
        m_req = 1'b0;
        m_buf.delete();
        m_instr = 32'h0;
        m_pc4 = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {sf, sd, ps, jp} = 4'b0;
        pb = 32'h0;
        pj = 32'h0;
        rdy = 1'b1;
        word_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic f, input logic d, input logic s,
                         input logic [31:0] b, input logic j,
                         input logic [31:0] jt, input logic r);
        sf = f; sd = d; ps = s; pb = b; jp = j; pj = jt; rdy = r;
        #1;
        m_req = m_pending | (!sf && m_buf.size() == 0);
    endtask

    task automatic tick();
        logic        redir, done, deliver;
        logic [31:0] tgt, word;
        redir   = (jp | ps) & !sd;
        tgt     = jp ? pj : pb;
        done    = m_req & rdy;
        deliver = done & !m_doomed & !redir;
        word    = word_en ? force_word : mem_word(m_pc);
        if (!sd) begin
            if (redir) begin
                {m_instr, m_pc4, m_valid} = {32'h0, 32'h0, 1'b0};
                m_buf.delete();
            end else if (m_buf.size() > 0) begin
                {m_instr, m_pc4} = m_buf.pop_front();
                m_valid = 1'b1;
                if (deliver) m_buf.push_back({word, m_pc + 32'd4});
            end else if (deliver) begin
                {m_instr, m_pc4, m_valid} = {word, m_pc + 32'd4, 1'b1};
            end else begin
                {m_instr, m_pc4, m_valid} = {32'h0, 32'h0, 1'b0};
            end
        end else if (deliver) begin
            m_buf.push_back({word, m_pc + 32'd4});
        end
        if (done) begin
            m_pc = m_doomed ? m_tgt : (redir ? tgt : m_pc + 32'd4);
            m_pending = 1'b0;
            m_doomed = 1'b0;
        end else if (m_req) begin
            if (redir && !m_doomed) begin
                m_doomed = 1'b1;
                m_tgt = tgt;
            end
            m_pending = 1'b1;
        end else if (redir) begin
            m_pc = tgt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {sf, sd, ps, jp} = 4'b0;
        pb = 32'h0; pj = 32'h0; rdy = 1'b1; word_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if ({instr_D, pc_plus4_D, valid_D} !== 65'h0)
            $display("FAIL reset_D got %h/%h/%b exp 0/0/0",
                     instr_D, pc_plus4_D, valid_D);
        else n_pass++;
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0})
            $display("FAIL reset_req got %b/%h exp 1/0",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        sf = 1'b1;
        #1;
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL reset_req_stall got %b exp 0", bus.imem_req);
        else n_pass++;
        sf = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
            n_total++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'(4 * i)})
                $display("FAIL seq_addr got %b/%h exp 1/%h",
                         bus.imem_req, bus.imem_addr, 4 * i);
            else n_pass++;
            tick();
            n_total++;
            if ({valid_D, pc_plus4_D, instr_D} !==
                {1'b1, 32'(4 * i + 4), mem_word(32'(4 * i))})
                $display("FAIL seq_D got %b/%h/%h exp 1/%h/%h", valid_D,
                         pc_plus4_D, instr_D, 4 * i + 4, mem_word(32'(4 * i)));
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        repeat (2) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0, i == 2);
            n_total++;
            if ({bus.imem_req, bus.imem_addr, fetch_busy} !==
                {1'b1, 32'h8, i != 2})
                $display("FAIL wait_hold got %b/%h/%b exp 1/8/%b",
                         bus.imem_req, bus.imem_addr, fetch_busy, i != 2);
            else n_pass++;
            tick();
            n_total++;
            if (valid_D !== (i == 2))
                $display("FAIL wait_valid got %b exp %b", valid_D, i == 2);
            else n_pass++;
        end
        n_total++;
        if ({instr_D, pc_plus4_D} !== {mem_word(32'h8), 32'hC})
            $display("FAIL wait_D got %h/%h exp %h/c", instr_D,
                     pc_plus4_D, mem_word(32'h8));
        else n_pass++;
    endtask

    task automatic test_stall_buffer();
        drive(0, 1, 0, 32'h0, 0, 32'h0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 32'h0, 0, 32'h0, 1);
            n_total++;
            if (bus.imem_req !== (i == 0))
                $display("FAIL stall_req got %b exp %b", bus.imem_req, i == 0);
            else n_pass++;
            tick();
            n_total++;
            if ({valid_D, instr_D, pc_plus4_D} !==
                {1'b1, mem_word(32'h8), 32'hC})
                $display("FAIL stall_hold got %b/%h/%h exp 1/%h/c",
                         valid_D, instr_D, pc_plus4_D, mem_word(32'h8));
            else n_pass++;
        end
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h10})
            $display("FAIL stall_drain_req got %b/%h exp 0/10",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({valid_D, instr_D, pc_plus4_D} !== {1'b1, mem_word(32'hC), 32'h10})
            $display("FAIL stall_buf_D got %b/%h/%h exp 1/%h/10",
                     valid_D, instr_D, pc_plus4_D, mem_word(32'hC));
        else n_pass++;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10})
            $display("FAIL stall_next_req got %b/%h exp 1/10",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch_jump();
        do_reset();
        drive(0, 0, 1, 32'h40, 0, 32'h0, 1);
        tick();
        n_total++;
        if ({valid_D, bus.imem_addr} !== {1'b0, 32'h40})
            $display("FAIL branch got %b/%h exp 0/40", valid_D, bus.imem_addr);
        else n_pass++;
        drive(0, 0, 1, 32'h200, 1, 32'h100, 1);
        tick();
        n_total++;
        if ({valid_D, bus.imem_addr} !== {1'b0, 32'h100})
            $display("FAIL jump_wins got %b/%h exp 0/100",
                     valid_D, bus.imem_addr);
        else n_pass++;
        drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
        tick();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        tick();
        n_total++;
        if ({valid_D, pc_plus4_D, bus.imem_addr} !== {1'b1, 32'h0, 32'h0})
            $display("FAIL pc_wrap got %b/%h/%h exp 1/0/0",
                     valid_D, pc_plus4_D, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        tick();
        drive(0, 0, 1, 32'h80, 0, 32'h0, 0);
        n_total++;
        if (fetch_busy !== 1'b1)
            $display("FAIL drain_busy got %b exp 1", fetch_busy);
        else n_pass++;
        tick();
        drive(0, 0, 1, 32'h300, 0, 32'h0, 0);
        tick();
        force_word = 32'hDEAD_BEEF;
        word_en = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0})
            $display("FAIL drain_addr got %b/%h exp 1/0",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        tick();
        word_en = 1'b0;
        n_total++;
        if ({valid_D, instr_D} !== {1'b0, 32'h0})
            $display("FAIL drain_drop got %b/%h exp 0/0", valid_D, instr_D);
        else n_pass++;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h80})
            $display("FAIL drain_target got %b/%h exp 1/80",
                     bus.imem_req, bus.imem_addr);
        else n_pass++;
        tick();
    endtask

    task automatic test_stall_redirect_and_reset();
        do_reset();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        tick();
        drive(1, 1, 1, 32'h40, 0, 32'h0, 1);
        tick();
        n_total++;
        if ({bus.imem_addr, valid_D, pc_plus4_D} !== {32'h4, 1'b1, 32'h4})
            $display("FAIL stalled_redirect got %h/%b/%h exp 4/1/4",
                     bus.imem_addr, valid_D, pc_plus4_D);
        else n_pass++;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        tick();
        drive(0, 0, 1, 32'h40, 0, 32'h0, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.imem_req, bus.imem_addr, valid_D, pc_plus4_D} !==
            {1'b1, 32'h0, 1'b0, 32'h0})
            $display("FAIL async_reset got %b/%h/%b/%h exp 1/0/0/0",
                     bus.imem_req, bus.imem_addr, valid_D, pc_plus4_D);
        else n_pass++;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        tick();
        n_total++;
        if ({valid_D, instr_D, pc_plus4_D} !== {1'b1, mem_word(32'h0), 32'h4})
            $display("FAIL reset_run got %b/%h/%h exp 1/%h/4",
                     valid_D, instr_D, pc_plus4_D, mem_word(32'h0));
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, {22'h0, 8'($urandom), 2'b00},
                  $urandom_range(0, 11) == 0, {22'h0, 8'($urandom), 2'b00},
                  $urandom_range(0, 2) != 0);
            n_total++;
            if ({bus.imem_req, bus.imem_addr, fetch_busy} !==
                {m_req, m_pc, m_req & !rdy})
                $display("FAIL rand_bus cyc %0d got %b/%h/%b exp %b/%h/%b", i,
                         bus.imem_req, bus.imem_addr, fetch_busy,
                         m_req, m_pc, m_req & !rdy);
            else n_pass++;
            tick();
            n_total++;
            if ({valid_D, instr_D, pc_plus4_D} !== {m_valid, m_instr, m_pc4})
                $display("FAIL rand_D cyc %0d got %b/%h/%h exp %b/%h/%h", i,
                         valid_D, instr_D, pc_plus4_D,
                         m_valid, m_instr, m_pc4);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        force_word = 32'h0;
        word_en = 1'b0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_buffer();
        test_branch_jump();
        test_redirect_wait();
        test_stall_redirect_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
